imem_loader: RTL and testbench

- Write-side counterpart to the uPOWER instruction fetch path. Fetch reads instruction memory as 32-bit words indexed by (PC - BASE_ADDR)/4.
- This block receives the program as a big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes them into instruction memory at consecutive word indices starting at 0.
- It holds the fetch stage in reset until loading completes, then releases it so fetch starts at PC = BASE_ADDR.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_word_packer.sv | 58 +++++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
// The fetch stage takes BASE_ADDR and DEPTH from here.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } load_state_t;

    localparam int          DEPTH_DEF     = 101;
    localparam int          ADDR_W_DEF    = 7;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0004_0000;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer with a 2-bit lane counter.
// A final byte on lanes 0..2 emits the word zero-padded, flagged by padded.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic        padded,
    output logic [1:0]  lane
);

    logic [23:0] held;
    logic [31:0] merged;

    // Bytes not yet received stay zero, which yields the padding for free
    always_comb begin
        merged = {held, 8'h00};
        unique case (lane)
            2'd0: merged = {byte_in, 24'h000000};
            2'd1: merged = {held[23:16], byte_in, 16'h0000};
            2'd2: merged = {held[23:8], byte_in, 8'h00};
            2'd3: merged = {held, byte_in};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held       <= '0;
            lane       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            padded     <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            padded     <= 1'b0;
            if (clear) begin
                held <= '0;
                lane <= '0;
            end else if (push) begin
                if (lane == 2'd3 || last) begin
                    word       <= merged;
                    word_valid <= 1'b1;
                    padded     <= (lane != 2'd3);
                    held       <= '0;
                    lane       <= '0;
                end else begin
                    held <= merged[31:8];
                    lane <= lane + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory and holds
// the fetch stage in reset until the whole program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = DEPTH_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_rst,
    output logic [31:0]       boot_pc,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    load_state_t     state;
    load_state_t     next;
    logic            xfer;
    logic            begin_load;
    logic            full;
    logic            word_valid;
    logic            padded;
    logic [1:0]      lane;
    logic [31:0]     word;
    logic [ADDR_W:0] count;

    assign xfer       = in_valid & in_ready;
    assign begin_load = start & ((state == IDLE) | (state == DONE));
    assign full       = (count == LIMIT);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (begin_load),
        .push       (xfer),
        .last       (in_last),
        .byte_in    (in_byte),
        .word_valid (word_valid),
        .word       (word),
        .padded     (padded),
        .lane       (lane)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = LOAD;
            LOAD:  if (xfer && in_last)
                       next = (lane == 2'd3) ? DONE : FLUSH;
            FLUSH: if (padded) next = DONE;
            DONE:  if (start) next = LOAD;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == LOAD);
        core_rst   = (state != DONE);
        load_done  = (state == DONE);
        wr_en      = word_valid & ~full;
        wr_addr    = count[ADDR_W-1:0];
        wr_data    = word;
        word_count = count;
        boot_pc    = BASE_ADDR;
    end

    // Index equals words written, so one saturating counter serves both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            err_overflow <= 1'b0;
        end else if (begin_load) begin
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (word_valid && !full) count <= count + 1'b1;
            if (full && (xfer || word_valid)) err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a byte-level reference model
// and a per-cycle output comparison.
module tb_imem_loader;

    localparam int DEPTH = 101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_rst;
    logic [31:0] boot_pc;
    logic        load_done;
    logic [7:0]  word_count;
    logic        err_overflow;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_rst     (core_rst),
        .boot_pc      (boot_pc),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef enum {M_IDLE, M_LOAD, M_FLUSH, M_DONE} mstate_t;
    mstate_t     m_state;
    int          m_lane;
    int          m_count;
    int          done_age;
    bit          m_err;
    logic [31:0] m_word;
    bit          exp_wr;
    int          exp_addr;
    logic [31:0] exp_data;
    int          log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_core_rst", core_rst, 1);
            chk("rst_load_done", load_done, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_err", err_overflow, 0);
            m_state = M_IDLE; m_lane = 0; m_count = 0; m_err = 0;
            m_word = 0; exp_wr = 0; done_age = 0;
        end else begin
            bit nwr;
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr) begin
                chk("wr_addr", wr_addr, exp_addr);
                chk("wr_data", wr_data, exp_data);
            end
            if (wr_en) begin
                log_addr.push_back(int'(wr_addr));
                log_data.push_back(wr_data);
            end
            chk("in_ready", in_ready, m_state == M_LOAD);
            chk("core_rst", core_rst, m_state != M_DONE);
            chk("load_done", load_done, m_state == M_DONE);
            chk("word_count", word_count, m_count - int'(exp_wr));
            chk("boot_pc", boot_pc, 32'h0004_0000);
            if (m_state == M_DONE && done_age >= 1)
                chk("err_overflow", err_overflow, m_err);
            nwr = 0;
            case (m_state)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_state = M_LOAD; m_count = 0; m_err = 0;
                        m_lane = 0; m_word = 0;
                    end else if (m_state == M_DONE) begin
                        done_age++;
                    end
                end
                M_LOAD: begin
                    if (in_valid) begin
                        if (m_count == DEPTH) m_err = 1;
                        m_word |= 32'(in_byte) << (8 * (3 - m_lane));
                        m_lane++;
                        if (m_lane == 4 || in_last) begin
                            if (m_count < DEPTH) begin
                                nwr = 1; exp_addr = m_count;
                                exp_data = m_word; m_count++;
                            end else begin
                                m_err = 1;
                            end
                            if (in_last) begin
                                m_state = (m_lane == 4) ? M_DONE : M_FLUSH;
                                done_age = 0;
                            end
                            m_lane = 0; m_word = 0;
                        end
                    end
                end
                M_FLUSH: begin
                    m_state = M_DONE; done_age = 0;
                end
            endcase
            exp_wr = nwr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random gaps and stray starts
    task automatic stream(input logic [7:0] b[$], input bit with_last, input int mode);
        int i = 0;
        int cyc = 0;
        while (i < b.size() && cyc < 4000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            start = (mode == 2) && ($urandom_range(0, 19) == 0);
            in_byte = b[i];
            in_last = with_last && (i == b.size() - 1);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        if (i < b.size()) chk("stream_timeout", i, b.size());
    endtask

    task automatic check_log(input int i, input int addr, input logic [31:0] data);
        if (i < log_addr.size()) begin
            chk("log_addr", log_addr[i], addr);
            chk("log_data", log_data[i], data);
        end else begin
            chk("log_len", log_addr.size(), i + 1);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);

        log_addr.delete(); log_data.delete();
        pulse_start();
        q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h38, 8'h20, 8'h00, 8'h05};
        stream(q, 1, 0);
        tick(3);
        chk("t1_writes", log_addr.size(), 2);
        check_log(0, 0, 32'h0001_0203);
        check_log(1, 1, 32'h3820_0005);
        chk("t1_done", load_done, 1);
        chk("t1_core_rst", core_rst, 0);
        chk("t1_count", word_count, 2);
        chk("t1_boot_pc", boot_pc, 32'h0004_0000);

        log_addr.delete(); log_data.delete();
        pulse_start();
        chk("restart_core_rst", core_rst, 1);
        chk("restart_done", load_done, 0);
        chk("restart_ready", in_ready, 1);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        stream(q, 1, 1);
        tick(3);
        chk("t2_writes", log_addr.size(), 1);
        check_log(0, 0, 32'hAABB_CCDD);

        log_addr.delete(); log_data.delete();
        pulse_start();
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stream(q, 1, 0);
        tick(3);
        chk("t3_writes", log_addr.size(), 2);
        check_log(0, 0, 32'h1122_3344);
        check_log(1, 1, 32'h5566_0000);
        chk("t3_done", load_done, 1);

        log_addr.delete(); log_data.delete();
        pulse_start();
        q.delete();
        for (int i = 0; i < 4 * (DEPTH + 2); i++) q.push_back(8'($urandom));
        stream(q, 1, 0);
        tick(3);
        chk("ovf_writes", log_addr.size(), DEPTH);
        check_log(DEPTH - 1, DEPTH - 1, {q[400], q[401], q[402], q[403]});
        chk("ovf_err", err_overflow, 1);
        chk("ovf_count", word_count, DEPTH);
        chk("ovf_done", load_done, 1);

        log_addr.delete(); log_data.delete();
        pulse_start();
        chk("start_clears_err", err_overflow, 0);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        stream(q, 0, 0);
        rst = 1'b0;
        #1;
        chk("async_ready", in_ready, 0);
        chk("async_core_rst", core_rst, 1);
        chk("async_wr_en", wr_en, 0);
        chk("async_count", word_count, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        log_addr.delete(); log_data.delete();
        pulse_start();
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        stream(q, 1, 0);
        tick(3);
        chk("t5_writes", log_addr.size(), 1);
        check_log(0, 0, 32'hDEAD_BEEF);

        repeat (10) begin
            int len;
            pulse_start();
            len = $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            stream(q, 1, 2);
            tick($urandom_range(1, 4));
        end

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
